// File: rtl/uart_frame_dumper.sv
// Streams a stored frame buffer to a byte UART: sync byte, frame count, then every word MSB byte first.
// Each word costs RD_LAT+1 fetch cycles; every byte waits for uart_busy_i low plus a full holdoff interval.
module uart_frame_dumper #(
    parameter int         X_COUNT        = 40,
    parameter int         Y_COUNT        = 30,
    parameter int         XW             = 6,
    parameter int         YW             = 5,
    parameter int         BYTES_PER_WORD = 4,
    parameter int         RD_LAT         = 1,
    parameter int         HOLDOFF_BITS   = 13,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input  logic                        sys_clk_i,
    input  logic                        sys_rst_n_i,
    input  logic                        trigger_i,
    input  logic                        continuous_i,
    output logic [XW-1:0]               read_x_o,
    output logic [YW-1:0]               read_y_o,
    input  logic [8*BYTES_PER_WORD-1:0] read_data_i,
    input  logic                        uart_busy_i,
    output logic                        uart_wr_o,
    output logic [7:0]                  uart_dat_o,
    output logic                        busy_o,
    output logic                        frame_done_o
);

    localparam int DW = 8 * BYTES_PER_WORD;
    localparam int BW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int LW = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(X_COUNT - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_COUNT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BYTES_PER_WORD - 1);
    localparam logic [LW-1:0] L_LAST = LW'(RD_LAT);

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        FETCH,
        SEND,
        DONE
    } state_t;

    state_t                  state;
    logic                    trig_q;
    logic [7:0]              frame_cnt;
    logic [HOLDOFF_BITS-1:0] hc;
    logic [DW-1:0]           word_q;
    logic [BW-1:0]           b;
    logic [LW-1:0]           lat_cnt;

    logic start;
    logic hc_sat;
    logic write_ok;

    assign start    = trigger_i & ~trig_q;
    assign hc_sat   = &hc;
    assign write_ok = hc_sat & ~uart_busy_i & ~uart_wr_o;

    // Holdoff restarts on every strobe and for as long as the UART reports busy.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            hc <= '0;
        end else if (uart_busy_i || uart_wr_o) begin
            hc <= '0;
        end else if (!hc_sat) begin
            hc <= hc + 1'b1;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            state        <= IDLE;
            trig_q       <= 1'b1;
            frame_cnt    <= '0;
            word_q       <= '0;
            b            <= '0;
            lat_cnt      <= '0;
            read_x_o     <= '0;
            read_y_o     <= '0;
            uart_wr_o    <= 1'b0;
            uart_dat_o   <= '0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            trig_q       <= trigger_i;
            uart_wr_o    <= 1'b0;
            frame_done_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (start || continuous_i) begin
                        read_x_o <= '0;
                        read_y_o <= '0;
                        busy_o   <= 1'b1;
                        state    <= HDR0;
                    end
                end

                HDR0: begin
                    if (write_ok) begin
                        uart_wr_o  <= 1'b1;
                        uart_dat_o <= SYNC_BYTE;
                        state      <= HDR1;
                    end
                end

                HDR1: begin
                    if (write_ok) begin
                        uart_wr_o  <= 1'b1;
                        uart_dat_o <= frame_cnt;
                        lat_cnt    <= '0;
                        state      <= FETCH;
                    end
                end

                // Address is held for the whole fetch; data is taken on its final cycle.
                FETCH: begin
                    if (lat_cnt == L_LAST) begin
                        word_q <= read_data_i;
                        b      <= '0;
                        state  <= SEND;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end

                SEND: begin
                    if (write_ok) begin
                        uart_wr_o  <= 1'b1;
                        uart_dat_o <= word_q[DW-1 -: 8];
                        word_q     <= word_q << 8;
                        if (b == B_LAST) begin
                            lat_cnt <= '0;
                            if (read_x_o == X_LAST && read_y_o == Y_LAST) begin
                                state <= DONE;
                            end else begin
                                if (read_x_o == X_LAST) begin
                                    read_x_o <= '0;
                                    read_y_o <= read_y_o + 1'b1;
                                end else begin
                                    read_x_o <= read_x_o + 1'b1;
                                end
                                state <= FETCH;
                            end
                        end else begin
                            b <= b + 1'b1;
                        end
                    end
                end

                DONE: begin
                    frame_done_o <= 1'b1;
                    frame_cnt    <= frame_cnt + 1'b1;
                    busy_o       <= 1'b0;
                    state        <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
